// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU:
//   - ALU_DATA_W : default operand/result width
//   - OP_*       : 4-bit ALU control codes, identical to the decoder output
//   - alu_state_e: execution FSM state type
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier producing the low DATA_W bits of a*b.
// One step per clock after start; exactly DATA_W steps, no early exit.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   start       : load operands (a, b) and begin iterating
//   a, b        : multiplicand / multiplier, sampled on start
//   busy        : iteration in progress
//   done        : current edge performs the final step (combinational)
//   product     : accumulator value after the current step (valid with done)
// ---------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic [DATA_W-1:0] step_sum_s;

    // Accumulator value after this step; also the final product on the last step.
    assign step_sum_s = acc_r + (mplier_r[0] ? mcand_r : {DATA_W{1'b0}});

    assign busy    = busy_r;
    assign done    = busy_r && (cnt_r == {CNT_W{1'b0}});
    assign product = step_sum_s;

    // Operand load on start, then one shift-add step per edge while busy.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mcand_r  <= {DATA_W{1'b0}};
            mplier_r <= {DATA_W{1'b0}};
            acc_r    <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= {DATA_W{1'b0}};
            cnt_r    <= CNT_LAST;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= step_sum_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            busy_r   <= (cnt_r != {CNT_W{1'b0}});
        end else begin
            busy_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
// Executes one ALU operation per valid/ready transfer. Single-cycle ops
// register their result on the accept edge; MUL runs the iterative
// multiplier for DATA_W cycles. The result is held until out_ready.
// Optional feature macro: ALU_MUL_EN (MUL support; code 8 is illegal without it).
// Ports:
//   clk, arst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (in_ready depends on out_ready)
//   alu_control          : 4-bit op code
//   alu_in_0, alu_in_1   : operands A and B (shift amount = low bits of B)
//   out_valid / out_ready: result handshake
//   alu_out, zero_flag, illegal : registered result and flags
// ---------------------------------------------------------------------------
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] alu_in_0,
    input  logic [DATA_W-1:0] alu_in_1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero_flag,
    output logic              illegal
);

    localparam int SH_W = $clog2(DATA_W);

    alu_state_e        state_r, next_state_s;
    logic              out_valid_r, valid_next_s;
    logic [DATA_W-1:0] alu_out_r, res_next_s;
    logic              zero_flag_r, zf_next_s;
    logic              illegal_r, ill_next_s;

    logic [DATA_W-1:0] op_res_s;
    logic              op_ill_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              is_mul_s;
    logic              mul_busy_s;
    logic              mul_done_s;
    logic [DATA_W-1:0] mul_prod_s;

    assign in_ready_s = arst_n && ((state_r == ST_IDLE) ||
                                   ((state_r == ST_DONE) && out_ready));
    assign accept_s   = in_valid && in_ready_s;

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign alu_out    = alu_out_r;
    assign zero_flag  = zero_flag_r;
    assign illegal    = illegal_r;

`ifdef ALU_MUL_EN
    logic mul_start_s;

    assign is_mul_s    = (alu_control == OP_MUL);
    assign mul_start_s = accept_s && is_mul_s;

    alu_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .arst_n  (arst_n),
        .start   (mul_start_s),
        .a       (alu_in_0),
        .b       (alu_in_1),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );
`else
    // Without MUL hardware code 8 falls through to the illegal path.
    assign is_mul_s   = 1'b0;
    assign mul_busy_s = 1'b0;
    assign mul_done_s = 1'b0;
    assign mul_prod_s = {DATA_W{1'b0}};
`endif

    // Single-cycle datapath; unsupported codes yield zero with illegal set.
    always_comb begin
        op_res_s = {DATA_W{1'b0}};
        op_ill_s = 1'b0;
        case (alu_control)
            OP_AND:  op_res_s = alu_in_0 & alu_in_1;
            OP_OR:   op_res_s = alu_in_0 | alu_in_1;
            OP_ADD:  op_res_s = alu_in_0 + alu_in_1;
            OP_SUB:  op_res_s = alu_in_0 - alu_in_1;
            OP_SLL:  op_res_s = alu_in_0 << alu_in_1[SH_W-1:0];
            OP_SRL:  op_res_s = alu_in_0 >> alu_in_1[SH_W-1:0];
            OP_SLT:  op_res_s = {{(DATA_W-1){1'b0}},
                                 ($signed(alu_in_0) < $signed(alu_in_1))};
            default: op_ill_s = 1'b1;
        endcase
    end

    // Next-state and next-result logic; registers hold unless updated.
    always_comb begin
        next_state_s = state_r;
        valid_next_s = out_valid_r;
        res_next_s   = alu_out_r;
        zf_next_s    = zero_flag_r;
        ill_next_s   = illegal_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s && is_mul_s) begin
                    next_state_s = ST_MUL;
                    valid_next_s = 1'b0;
                end else if (accept_s) begin
                    next_state_s = ST_DONE;
                    valid_next_s = 1'b1;
                    res_next_s   = op_res_s;
                    zf_next_s    = (op_res_s == {DATA_W{1'b0}});
                    ill_next_s   = op_ill_s;
                end else if ((state_r == ST_DONE) && out_ready) begin
                    next_state_s = ST_IDLE;
                    valid_next_s = 1'b0;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    next_state_s = ST_DONE;
                    valid_next_s = 1'b1;
                    res_next_s   = mul_prod_s;
                    zf_next_s    = (mul_prod_s == {DATA_W{1'b0}});
                    ill_next_s   = 1'b0;
                end else if (!mul_busy_s) begin
                    // Multiplier lost its operation: recover to IDLE.
                    next_state_s = ST_IDLE;
                    valid_next_s = 1'b0;
                end else begin
                    next_state_s = ST_MUL;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // State and registered result/flag outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            alu_out_r   <= {DATA_W{1'b0}};
            zero_flag_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            out_valid_r <= valid_next_s;
            alu_out_r   <= res_next_s;
            zero_flag_r <= zf_next_s;
            illegal_r   <= ill_next_s;
        end
    end

endmodule
